// File: rtl/uart_frame_rx_pkg.sv
// Shared types and constants for the UART frame decoder.
package uart_frame_rx_pkg;

  // Frame parser states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  // Completion status codes reported with o_done.
  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_CHK = 2'd1;
  localparam logic [1:0] ST_LEN = 2'd2;
  localparam logic [1:0] ST_TO  = 2'd3;

  // Default frame start byte.
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_frame_timer.sv
// Mid-frame idle timer: counts enabled cycles, saturates at TIMEOUT and
// flags expiry while the count sits at TIMEOUT.
module frame_timer #(
  parameter int TIMEOUT  = 50000,
  parameter int WIDTH_TO = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [WIDTH_TO-1:0] TO_W  = WIDTH_TO'(TIMEOUT);
  localparam logic [WIDTH_TO-1:0] ONE_W = WIDTH_TO'(1);

  logic [WIDTH_TO-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up while enabled until saturated.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != TO_W)) begin
      count_d = count_q + ONE_W;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = (count_q == TO_W);

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder behind the uart receive side: hunts SYNC, parses
// CMD/LEN/PAYLOAD/CHK, streams payload bytes and reports a status per frame.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int                    WIDTH_DATA = 8,
  parameter logic [WIDTH_DATA-1:0] SYNC       = SYNC_DEFAULT,
  parameter int                    MAX_LEN    = 64,
  parameter int                    TIMEOUT    = 50000,
  parameter int                    WIDTH_TO   = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WIDTH_DATA-1:0] i_rx_data,
  input  logic                  i_rx_rdy,
  output logic                  o_rx_re,
  output logic [WIDTH_DATA-1:0] o_pay_data,
  output logic                  o_pay_valid,
  input  logic                  i_pay_ready,
  output logic [WIDTH_DATA-1:0] o_cmd,
  output logic [WIDTH_DATA-1:0] o_len,
  output logic                  o_done,
  output logic [1:0]            o_status,
  output logic                  o_drop
);

  localparam logic [WIDTH_DATA-1:0] MAX_LEN_W = WIDTH_DATA'(MAX_LEN);
  localparam logic [WIDTH_DATA-1:0] ONE_W     = WIDTH_DATA'(1);

  state_t                state_q, state_d;
  logic [WIDTH_DATA-1:0] cmd_q, cmd_d;
  logic [WIDTH_DATA-1:0] len_q, len_d;
  logic [WIDTH_DATA-1:0] acc_q, acc_d;
  logic [WIDTH_DATA-1:0] cnt_q, cnt_d;
  logic [1:0]            status_q, status_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;

  logic                  consume;
  logic                  expire;
  logic                  timer_clear;
  logic                  timer_enable;
  logic [WIDTH_DATA-1:0] sum;
  logic [WIDTH_DATA-1:0] cnt_inc;

  // Payload is a straight pass-through; the uart is only popped when downstream takes the byte.
  assign o_rx_re     = (state_q == S_PAYLOAD) ? i_pay_ready : 1'b1;
  assign o_pay_valid = (state_q == S_PAYLOAD) && i_rx_rdy;
  assign o_pay_data  = i_rx_data;
  assign consume     = i_rx_rdy && o_rx_re;

  assign sum     = acc_q + i_rx_data;
  assign cnt_inc = cnt_q + ONE_W;

  // Timer only runs mid-frame while the uart is empty; a stalled downstream holds it.
  assign timer_clear  = consume || (state_q == S_IDLE) || expire;
  assign timer_enable = (state_q != S_IDLE) && !i_rx_rdy;

  frame_timer #(
    .TIMEOUT  (TIMEOUT),
    .WIDTH_TO (WIDTH_TO)
  ) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .i_clear  (timer_clear),
    .i_enable (timer_enable),
    .o_expire (expire)
  );

  // Next-state, field capture, checksum accumulation and completion reporting.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    done_d   = 1'b0;
    drop_d   = 1'b0;

    if ((state_q != S_IDLE) && expire) begin
      done_d   = 1'b1;
      status_d = ST_TO;
      state_d  = S_IDLE;
    end else if (consume) begin
      case (state_q)
        S_IDLE: begin
          if (i_rx_data == SYNC) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_CMD;
          end else begin
            drop_d = 1'b1;
          end
        end
        S_CMD: begin
          cmd_d   = i_rx_data;
          acc_d   = sum;
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d = i_rx_data;
          acc_d = sum;
          if (i_rx_data > MAX_LEN_W) begin
            done_d   = 1'b1;
            status_d = ST_LEN;
            state_d  = S_IDLE;
          end else if (i_rx_data == '0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          acc_d = sum;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_CHK;
          end
        end
        S_CHK: begin
          acc_d    = sum;
          done_d   = 1'b1;
          status_d = (sum == '0) ? ST_OK : ST_CHK;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      status_q <= ST_OK;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign o_cmd    = cmd_q;
  assign o_len    = len_q;
  assign o_status = status_q;
  assign o_done   = done_q;
  assign o_drop   = drop_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: one task per scenario, inline checks.
module tb_uart_frame_rx;

  localparam int TO = 500;

  logic       clk;
  logic       nrst;
  logic [7:0] i_rx_data;
  logic       i_rx_rdy;
  logic       o_rx_re;
  logic [7:0] o_pay_data;
  logic       o_pay_valid;
  logic       i_pay_ready;
  logic [7:0] o_cmd;
  logic [7:0] o_len;
  logic       o_done;
  logic [1:0] o_status;
  logic       o_drop;

  int checks = 0;
  int errors = 0;

  logic [7:0] pay_q[$];
  logic [1:0] done_q[$];
  int         drop_cnt = 0;

  uart_frame_rx #(
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_rx_data   (i_rx_data),
    .i_rx_rdy    (i_rx_rdy),
    .o_rx_re     (o_rx_re),
    .o_pay_data  (o_pay_data),
    .o_pay_valid (o_pay_valid),
    .i_pay_ready (i_pay_ready),
    .o_cmd       (o_cmd),
    .o_len       (o_len),
    .o_done      (o_done),
    .o_status    (o_status),
    .o_drop      (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe accepted payload, completions and drops mid-cycle.
  always @(negedge clk) begin
    if (nrst) begin
      if (o_pay_valid && i_pay_ready) pay_q.push_back(o_pay_data);
      if (o_done) begin
        done_q.push_back(o_status);
        $display("frame done status %0d cmd %h len %h", o_status, o_cmd, o_len);
      end
      if (o_drop) drop_cnt++;
    end
  end

  // Present one byte; it is consumed on the next edge when o_rx_re is high.
  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx_rdy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; i_rx_rdy = 1'b0; i_rx_data = 8'h00; i_pay_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_rx_re !== 1'b1) begin errors++; $display("FAIL reset_rx_re got %b exp 1", o_rx_re); end
    checks++; if (o_pay_valid !== 1'b0) begin errors++; $display("FAIL reset_pay_valid got %b exp 0", o_pay_valid); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_done); end
    checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", o_drop); end
    checks++; if (o_cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h exp 00", o_cmd); end
    checks++; if (o_len !== 8'h00) begin errors++; $display("FAIL reset_len got %h exp 00", o_len); end
    checks++; if (o_status !== 2'd0) begin errors++; $display("FAIL reset_status got %0d exp 0", o_status); end
    nrst = 1'b1;
  endtask

  task automatic test_frame_ok();
    int pb = pay_q.size();
    int db = done_q.size();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'hBB);
    idle(3);
    checks++; if (pay_q.size() - pb !== 2) begin errors++; $display("FAIL ok_pay_count got %0d exp 2", pay_q.size() - pb); end
    else begin
      checks++; if (pay_q[pb] !== 8'h11) begin errors++; $display("FAIL ok_pay0 got %h exp 11", pay_q[pb]); end
      checks++; if (pay_q[pb+1] !== 8'h22) begin errors++; $display("FAIL ok_pay1 got %h exp 22", pay_q[pb+1]); end
    end
    checks++; if (o_cmd !== 8'h10) begin errors++; $display("FAIL ok_cmd got %h exp 10", o_cmd); end
    checks++; if (o_len !== 8'h02) begin errors++; $display("FAIL ok_len got %h exp 02", o_len); end
    checks++; if (done_q.size() - db !== 1) begin errors++; $display("FAIL ok_done_count got %0d exp 1", done_q.size() - db); end
    else begin
      checks++; if (done_q[db] !== 2'd0) begin errors++; $display("FAIL ok_status got %0d exp 0", done_q[db]); end
    end
  endtask

  task automatic test_checksum_error();
    int pb = pay_q.size();
    int db = done_q.size();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'hBC);
    idle(3);
    checks++; if (pay_q.size() - pb !== 2) begin errors++; $display("FAIL chk_pay_count got %0d exp 2", pay_q.size() - pb); end
    checks++; if (done_q.size() - db !== 1) begin errors++; $display("FAIL chk_done_count got %0d exp 1", done_q.size() - db); end
    else begin
      checks++; if (done_q[db] !== 2'd1) begin errors++; $display("FAIL chk_status got %0d exp 1", done_q[db]); end
    end
    checks++; if (o_status !== 2'd1) begin errors++; $display("FAIL chk_status_hold got %0d exp 1", o_status); end
  endtask

  task automatic test_drop();
    int pb = pay_q.size();
    int db = done_q.size();
    int rb = drop_cnt;
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h05); send(8'h00); send(8'hFB);
    idle(3);
    checks++; if (drop_cnt - rb !== 2) begin errors++; $display("FAIL drop_count got %0d exp 2", drop_cnt - rb); end
    checks++; if (pay_q.size() - pb !== 0) begin errors++; $display("FAIL drop_pay_count got %0d exp 0", pay_q.size() - pb); end
    checks++; if (o_cmd !== 8'h05) begin errors++; $display("FAIL drop_cmd got %h exp 05", o_cmd); end
    checks++; if (o_len !== 8'h00) begin errors++; $display("FAIL drop_len got %h exp 00", o_len); end
    checks++; if (done_q.size() - db !== 1) begin errors++; $display("FAIL drop_done_count got %0d exp 1", done_q.size() - db); end
    else begin
      checks++; if (done_q[db] !== 2'd0) begin errors++; $display("FAIL drop_status got %0d exp 0", done_q[db]); end
    end
  endtask

  task automatic test_length_error();
    int db = done_q.size();
    int rb = drop_cnt;
    send(8'hA5); send(8'h10); send(8'h41);
    idle(1);
    checks++; if (done_q.size() - db !== 1) begin errors++; $display("FAIL len_done_count got %0d exp 1", done_q.size() - db); end
    else begin
      checks++; if (done_q[db] !== 2'd2) begin errors++; $display("FAIL len_status got %0d exp 2", done_q[db]); end
    end
    send(8'h01); send(8'h02);
    idle(3);
    checks++; if (o_len !== 8'h41) begin errors++; $display("FAIL len_len got %h exp 41", o_len); end
    checks++; if (drop_cnt - rb !== 2) begin errors++; $display("FAIL len_drop_count got %0d exp 2", drop_cnt - rb); end
  endtask

  task automatic test_timeout();
    int pb = pay_q.size();
    int edges = 0;
    int found = -1;
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
    i_rx_rdy = 1'b0;
    for (int k = 0; k < TO + 10; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (o_done && found < 0) found = edges;
    end
    @(posedge clk);
    #1;
    checks++; if (found !== TO + 1) begin errors++; $display("FAIL to_latency got %0d exp %0d", found, TO + 1); end
    checks++; if (o_status !== 2'd3) begin errors++; $display("FAIL to_status got %0d exp 3", o_status); end
    checks++; if (pay_q.size() - pb !== 1) begin errors++; $display("FAIL to_pay_count got %0d exp 1", pay_q.size() - pb); end
  endtask

  task automatic test_mid_reset();
    int db = done_q.size();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
    i_pay_ready = 1'b0;
    i_rx_data   = 8'h22;
    i_rx_rdy    = 1'b1;
    @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    checks++; if (o_rx_re !== 1'b1) begin errors++; $display("FAIL mrst_rx_re got %b exp 1", o_rx_re); end
    checks++; if (o_pay_valid !== 1'b0) begin errors++; $display("FAIL mrst_pay_valid got %b exp 0", o_pay_valid); end
    checks++; if (o_cmd !== 8'h00) begin errors++; $display("FAIL mrst_cmd got %h exp 00", o_cmd); end
    checks++; if (o_len !== 8'h00) begin errors++; $display("FAIL mrst_len got %h exp 00", o_len); end
    checks++; if (o_status !== 2'd0) begin errors++; $display("FAIL mrst_status got %0d exp 0", o_status); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL mrst_done got %b exp 0", o_done); end
    @(posedge clk);
    #1;
    i_rx_rdy    = 1'b0;
    i_pay_ready = 1'b1;
    nrst        = 1'b1;
    idle(3);
    checks++; if (done_q.size() - db !== 0) begin errors++; $display("FAIL mrst_done_count got %0d exp 0", done_q.size() - db); end
  endtask

  task automatic test_stall();
    int pb = pay_q.size();
    int db = done_q.size();
    i_pay_ready = 1'b1;
    send(8'hA5); send(8'h10); send(8'h02);
    i_pay_ready = 1'b0;
    i_rx_data   = 8'h11;
    i_rx_rdy    = 1'b1;
    repeat (4 * TO) @(posedge clk);
    @(negedge clk);
    checks++; if (o_rx_re !== 1'b0) begin errors++; $display("FAIL stall_rx_re got %b exp 0", o_rx_re); end
    checks++; if (o_pay_valid !== 1'b1) begin errors++; $display("FAIL stall_pay_valid got %b exp 1", o_pay_valid); end
    checks++; if (o_pay_data !== 8'h11) begin errors++; $display("FAIL stall_pay_data got %h exp 11", o_pay_data); end
    checks++; if (done_q.size() - db !== 0) begin errors++; $display("FAIL stall_no_timeout got %0d exp 0", done_q.size() - db); end
    @(posedge clk);
    #1;
    i_pay_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'hBB);
    idle(3);
    checks++; if (pay_q.size() - pb !== 2) begin errors++; $display("FAIL stall_pay_count got %0d exp 2", pay_q.size() - pb); end
    else begin
      checks++; if (pay_q[pb] !== 8'h11) begin errors++; $display("FAIL stall_pay0 got %h exp 11", pay_q[pb]); end
      checks++; if (pay_q[pb+1] !== 8'h22) begin errors++; $display("FAIL stall_pay1 got %h exp 22", pay_q[pb+1]); end
    end
    checks++; if (done_q.size() - db !== 1) begin errors++; $display("FAIL stall_done_count got %0d exp 1", done_q.size() - db); end
    else begin
      checks++; if (done_q[db] !== 2'd0) begin errors++; $display("FAIL stall_status got %0d exp 0", done_q[db]); end
    end
  endtask

  task automatic test_back_to_back();
    int pb = pay_q.size();
    int db = done_q.size();
    int rb = drop_cnt;
    // Second SYNC is consumed in the cycle the first frame's done is high; payload A5 is plain data.
    send(8'hA5); send(8'h01); send(8'h00); send(8'hFF);
    send(8'hA5); send(8'h02); send(8'h01); send(8'hA5); send(8'h58);
    idle(3);
    checks++; if (done_q.size() - db !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_q.size() - db); end
    else begin
      checks++; if (done_q[db] !== 2'd0) begin errors++; $display("FAIL b2b_status0 got %0d exp 0", done_q[db]); end
      checks++; if (done_q[db+1] !== 2'd0) begin errors++; $display("FAIL b2b_status1 got %0d exp 0", done_q[db+1]); end
    end
    checks++; if (pay_q.size() - pb !== 1) begin errors++; $display("FAIL b2b_pay_count got %0d exp 1", pay_q.size() - pb); end
    else begin
      checks++; if (pay_q[pb] !== 8'hA5) begin errors++; $display("FAIL b2b_pay0 got %h exp a5", pay_q[pb]); end
    end
    checks++; if (drop_cnt - rb !== 0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop_cnt - rb); end
    checks++; if (o_cmd !== 8'h02) begin errors++; $display("FAIL b2b_cmd got %h exp 02", o_cmd); end
    checks++; if (o_len !== 8'h01) begin errors++; $display("FAIL b2b_len got %h exp 01", o_len); end
  endtask

  initial begin
    test_reset();
    test_frame_ok();
    test_checksum_error();
    test_drop();
    test_length_error();
    test_timeout();
    test_mid_reset();
    test_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
